// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg -- shared CPU defines used by the memory controller.
//   IO_SEL_DEFAULT : addr[17:16] value that selects the memory-mapped I/O region
//   mc_state_e     : memory controller FSM states
//   CNT_W/CNT_LAST : fetch byte counter width and terminal value
//   byte_addr()    : 32-bit wrapping base + byte offset
package mem_ctrl_pkg;

   localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

   localparam int unsigned CNT_W = 3;
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = 3'd1;
   localparam logic [CNT_W-1:0] CNT_LAST = 3'd4;

   typedef enum logic {
      IDLE    = 1'b0,
      IF_BUSY = 1'b1
   } mc_state_e;

   // Plain 32-bit add: carries out of bit 31 are dropped, so addresses wrap.
   function automatic logic [31:0] byte_addr(input logic [31:0] base,
                                             input logic [CNT_W-1:0] off);
      return base + {{(32 - CNT_W){1'b0}}, off};
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl -- byte-wide RAM arbiter between the load/store buffer and
// instruction fetch.
//   clk_in, rst_in (sync, active-high), rdy_in (low freezes all state)
//   control_hazard : ROB flush, returns to IDLE and drops any fetch
//   io_buffer_full : UART TX full, blocks grants into the I/O region
//   mem_din/mem_dout/mem_a/mem_wr : byte RAM port (read data one cycle late)
//   slb_req/slb_addr/slb_wr/slb_dout -> slb_grant/slb_din : one byte per grant
//   if_req/if_addr -> if_done/if_inst : 4-byte little-endian fetch burst
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter logic [1:0] IO_SEL = IO_SEL_DEFAULT
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        control_hazard,
   input  logic        io_buffer_full,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        slb_req,
   input  logic [31:0] slb_addr,
   input  logic        slb_wr,
   input  logic [7:0]  slb_dout,
   output logic        slb_grant,
   output logic [7:0]  slb_din,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_inst
);

   mc_state_e          state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [31:0]        fetch_addr, fetch_addr_nxt;
   logic [31:0]        if_inst_nxt;
   logic               if_done_nxt;
   logic               io_blocked;

   assign slb_din = mem_din;

   // Depends only on address and full flag, never on slb_wr/slb_dout.
   assign io_blocked = (slb_addr[17:16] == IO_SEL) && io_buffer_full;

   always_ff @(posedge clk_in) begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      fetch_addr <= fetch_addr_nxt;
      if_inst    <= if_inst_nxt;
      if_done    <= if_done_nxt;
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      fetch_addr_nxt = fetch_addr;
      if_inst_nxt    = if_inst;
      if_done_nxt    = if_done;
      slb_grant      = 1'b0;
      mem_a          = '0;
      mem_dout       = '0;
      mem_wr         = 1'b0;

      if (rst_in) begin
         state_nxt   = IDLE;
         cnt_nxt     = '0;
         if_inst_nxt = '0;
         if_done_nxt = 1'b0;
      end else if (!rdy_in) begin
         // Frozen mid-burst: re-present the address whose byte is captured
         // next, so mem_din still holds it when rdy_in returns.
         if (state == IF_BUSY && cnt != CNT_ZERO && cnt <= CNT_LAST) begin
            mem_a = byte_addr(fetch_addr, cnt - CNT_ONE);
         end else if (state == IF_BUSY) begin
            mem_a = fetch_addr;
         end
      end else begin
         if_done_nxt = 1'b0;
         unique case (state)
            IDLE: begin
               if (!control_hazard) begin
                  if (slb_req) begin
                     if (!io_blocked) begin
                        slb_grant = 1'b1;
                        mem_a     = slb_addr;
                        mem_dout  = slb_dout;
                        mem_wr    = slb_wr;
                     end
                  end else if (if_req) begin
                     state_nxt      = IF_BUSY;
                     fetch_addr_nxt = if_addr;
                     cnt_nxt        = '0;
                  end
               end
            end

            IF_BUSY: begin
               if (cnt < CNT_LAST) begin
                  mem_a = byte_addr(fetch_addr, cnt);
               end
               if (control_hazard) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else begin
                  // mem_din now carries the byte addressed at cnt-1.
                  case (cnt)
                     3'd1:    if_inst_nxt[7:0]   = mem_din;
                     3'd2:    if_inst_nxt[15:8]  = mem_din;
                     3'd3:    if_inst_nxt[23:16] = mem_din;
                     3'd4:    if_inst_nxt[31:24] = mem_din;
                     default: ;
                  endcase
                  if (cnt >= CNT_LAST) begin
                     state_nxt   = IDLE;
                     cnt_nxt     = '0;
                     if_done_nxt = 1'b1;
                  end else begin
                     cnt_nxt = cnt + CNT_ONE;
                  end
               end
            end

            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

endmodule
